tff_counter: RTL
================

TFF_COUNTER -- requirements
Module: tff_counter

Interface
REQ-001 Parameter WIDTH, default 4: counter/register width in bits, legal range 1..32.
REQ-002 Parameter MAX, default 2**WIDTH-1: terminal count, legal range 1..2**WIDTH-1.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port en  input  1  count enable.
REQ-006 Port up  input  1  direction: 1 = count up, 0 = count down.
REQ-007 Port load  input  1  synchronous parallel load strobe.
REQ-008 Port d  input  WIDTH  parallel load value.
REQ-009 Port q  output  WIDTH  registered count value.
REQ-010 Port q_  output  WIDTH  bitwise complement of q, always ~q.
REQ-011 Port tc  output  1  terminal-count flag, combinational from registered state and inputs.

Function
REQ-012 Per-edge priority SHALL be: rst > load > en; with none active, q holds.
REQ-013 load=1: q SHALL take min(d, MAX) next edge; d > MAX loads MAX; en and up are ignored.
REQ-014 en=1, up=1, q<MAX: q SHALL become q+1 next edge.
REQ-015 en=1, up=1, q==MAX: q SHALL wrap to 0 next edge (default build).
REQ-016 en=1, up=0, q>0: q SHALL become q-1 next edge.
REQ-017 en=1, up=0, q==0: q SHALL wrap to MAX next edge (default build).
REQ-018 Count latency SHALL be one clock: the value at edge n+1 reflects inputs sampled at edge n.
REQ-019 tc SHALL equal en AND (up ? q==MAX : q==0); tc=0 whenever en=0.
REQ-020 Direction change SHALL take effect on the same edge it is sampled; no extra latency.
REQ-021 Each bit SHALL be held in a T-type cell; toggle vector = q XOR next_q; no bit toggles when next_q==q.
REQ-022 q SHALL never hold a value > MAX after any edge.
REQ-023 q_ SHALL equal ~q at all times, including during and after reset.

Reset
REQ-024 rst=1 at an edge SHALL force q=0 (q_=all ones) regardless of load/en.
REQ-025 rst asserted mid-count SHALL abort the count; counting resumes from 0 on the first edge with rst=0 and en=1.
REQ-026 tc SHALL read up ? 0 : en during reset (q==0), consistent with REQ-019.

Configuration
REQ-027 Macro TFF_COUNTER_SAT_EN defined: counter SHALL saturate -- up at MAX holds MAX, down at 0 holds 0; tc still asserts per REQ-019.
REQ-028 Macro TFF_COUNTER_SAT_EN undefined: wrap behaviour of REQ-015/REQ-017 SHALL apply.

Structure
REQ-029 Shared package tff_pkg SHALL hold direction constants (DIR_UP=1, DIR_DOWN=0) and the default WIDTH constant.
REQ-030 Sub-module tff_cell SHALL implement one T flip-flop (ports t, clk, rst, q, q_; synchronous active-high reset to 0), instantiated WIDTH times via generate.
REQ-031 Next-state, clamp and toggle-vector logic SHALL reside in tff_counter; no latches, no clocks derived from q.

Verification (WIDTH=4, MAX=9)
REQ-032 rst=1 for 3 edges with en=1, load=1, d=5 -> q=0, q_=4'hF after each edge.
REQ-033 en=1, up=1 from q=0 for 12 edges -> q sequence 1..9,0,1,2; tc=1 only while q==9.
REQ-034 en=1, up=0 from q=2 for 4 edges -> 1,0,9,8; tc=1 while q==0; with TFF_COUNTER_SAT_EN -> 1,0,0,0.
REQ-035 load=1, d=13 with en=1, up=1 -> q=9 next edge; then load=1, d=3 -> q=3.
REQ-036 Count up to q=6, assert rst for one edge with en=1 -> q=0; release -> q=1 next edge.
REQ-037 en=0 for 5 edges at q=4, up toggling -> q stays 4, tc=0 throughout.

Source files
------------

// File: rtl/tff_pkg.sv
// Shared constants for the T-flip-flop counter: direction encodings and default width.
package tff_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/tff_cell.sv
// Single T flip-flop with synchronous active-high reset to 0 and complement output.
module tff_cell (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q,
    output logic q_
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else if (t) begin
            q <= ~q;
        end
    end

    assign q_ = ~q;

endmodule

// File: rtl/tff_counter.sv
// Up/down counter with parallel load built from WIDTH T flip-flops; terminal count MAX.
// Define TFF_COUNTER_SAT_EN to saturate at 0/MAX instead of wrapping.
module tff_counter
    import tff_pkg::*;
#(
    parameter int               WIDTH = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] MAX   = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_,
    output logic             tc
);

    logic [WIDTH-1:0] d_clamped;
    logic [WIDTH-1:0] next_q;
    logic [WIDTH-1:0] toggle;
    logic             at_top;
    logic             at_bottom;

    assign d_clamped = (d > MAX) ? MAX : d;
    // >= rather than == keeps the counter inside 0..MAX even from an unexpected state.
    assign at_top    = (q >= MAX);
    assign at_bottom = (q == '0);

    always_comb begin
        next_q = q;
        if (load) begin
            next_q = d_clamped;
        end else if (en) begin
            if (up == DIR_UP) begin
`ifdef TFF_COUNTER_SAT_EN
                next_q = at_top ? MAX : q + WIDTH'(1);
`else
                next_q = at_top ? '0 : q + WIDTH'(1);
`endif
            end else begin
`ifdef TFF_COUNTER_SAT_EN
                next_q = at_bottom ? '0 : q - WIDTH'(1);
`else
                next_q = at_bottom ? MAX : q - WIDTH'(1);
`endif
            end
        end
    end

    // Only bits that differ between current and next value flip; reset is handled in each cell.
    assign toggle = q ^ next_q;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_cell
            tff_cell u_cell (
                .clk (clk),
                .rst (rst),
                .t   (toggle[i]),
                .q   (q[i]),
                .q_  (q_[i])
            );
        end
    endgenerate

    assign tc = en & ((up == DIR_UP) ? (q == MAX) : at_bottom);

endmodule
